// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam logic [31:0] PC_INC          = 32'd4;
  localparam int          TIMEOUT_DEFAULT = 16;

  // The timer counts one past TIMEOUT-1 on the expiring edge, so it needs room for TIMEOUT.
  function automatic int timer_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch sequencer, instruction memory and the downstream pipeline.
interface fetch_unit_if;

  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instr_out;
  logic        instr_en;
  logic [31:0] pc_out;
  logic        fault;

  modport master (
    input  stall, redirect, redirect_target, mem_ack, mem_rdata,
    output mem_req, mem_addr, instr_out, instr_en, pc_out, fault
  );

  modport slave (
    output stall, redirect, redirect_target, mem_ack, mem_rdata,
    input  mem_req, mem_addr, instr_out, instr_en, pc_out, fault
  );

endinterface

// File: rtl/fetch_timer.sv
// Wait-cycle counter for an outstanding memory request; flags expiry at TIMEOUT-1.
module fetch_timer
  import fetch_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire
);

  localparam int TW = timer_width(TIMEOUT);

  logic [TW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst)       r_count <= '0;
    else if (i_clr) r_count <= '0;
    else if (i_inc) r_count <= r_count + TW'(1);
  end

  assign o_expire = (r_count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_unit.sv
// Multi-cycle fetch sequencer: owns the PC, runs the req/ack handshake with
// instruction memory and pulses instr_en once per delivered word.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  state_e      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_mem_addr;
  logic [31:0] r_instr_out;
  logic [31:0] r_pc_out;
  logic        r_mem_req;
  logic        r_instr_en;
  logic        r_fault;
  logic        r_squash;
  logic        r_misalign;

  logic        w_aligned;
  logic        w_expire;
  logic        w_timer_clr;
  logic        w_timer_inc;

  assign w_aligned   = (bus.redirect_target[1:0] == 2'b00);
  assign w_timer_clr = (r_state != ST_WAIT) || bus.mem_ack;
  assign w_timer_inc = (r_state == ST_WAIT);

  fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_timer_clr),
    .i_inc    (w_timer_inc),
    .o_expire (w_expire)
  );

  // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_pc        <= RESET_PC;
      r_mem_addr  <= RESET_PC;
      r_mem_req   <= 1'b0;
      r_instr_out <= '0;
      r_instr_en  <= 1'b0;
      r_pc_out    <= '0;
      r_fault     <= 1'b0;
      r_squash    <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      r_instr_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.redirect) begin
            if (w_aligned) begin
              r_pc <= bus.redirect_target;
            end else begin
              r_state <= ST_FAULT;
              r_fault <= 1'b1;
            end
          end else if (!bus.stall) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_pc;
            r_state    <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (bus.mem_ack) begin
            r_mem_req  <= 1'b0;
            r_squash   <= 1'b0;
            r_misalign <= 1'b0;
            if (bus.redirect && w_aligned) r_pc <= bus.redirect_target;
            // A word fetched before a redirect belongs to the abandoned path.
            if (!r_squash && !bus.redirect) begin
              r_instr_out <= bus.mem_rdata;
              r_pc_out    <= r_mem_addr;
              r_pc        <= r_pc + PC_INC;
              r_instr_en  <= 1'b1;
            end
            if (r_misalign || (bus.redirect && !w_aligned)) begin
              r_state <= ST_FAULT;
              r_fault <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (w_expire) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_FAULT;
            r_fault   <= 1'b1;
          end else if (bus.redirect) begin
            // The outstanding request is never withdrawn; only its data is dropped.
            r_squash <= 1'b1;
            if (w_aligned) r_pc       <= bus.redirect_target;
            else           r_misalign <= 1'b1;
          end
        end

        ST_FAULT: begin
          r_mem_req <= 1'b0;
          r_fault   <= 1'b1;
        end

        default: begin
          r_mem_req <= 1'b0;
          r_state   <= ST_FAULT;
          r_fault   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.instr_out = r_instr_out;
  assign bus.instr_en  = r_instr_en;
  assign bus.pc_out    = r_pc_out;
  assign bus.fault     = r_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus timeout and PC-wrap sequences.
module tb_fetch_unit;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        redir;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_en;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_fault;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  vec_t vq[$];

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic rd, input logic [31:0] t,
                              input logic a, input logic [31:0] d, input logic q,
                              input logic [31:0] ad, input logic en, input logic [31:0] ins,
                              input logic [31:0] pc, input logic f);
    vec_t v;
    v.rst_n = r;  v.stall = s;  v.redir = rd;  v.tgt = t;  v.ack = a;  v.rdata = d;
    v.e_req = q;  v.e_addr = ad; v.e_en = en;  v.e_instr = ins; v.e_pc = pc; v.e_fault = f;
    return v;
  endfunction

  task automatic drive(input logic r, input logic s, input logic rd, input logic [31:0] t,
                       input logic a, input logic [31:0] d);
    rst                 = r;
    bus.stall           = s;
    bus.redirect        = rd;
    bus.redirect_target = t;
    bus.mem_ack         = a;
    bus.mem_rdata       = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    n_cmp  = 0;
    n_fail = 0;
    rst = 1'b0;
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_target = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;

    //            rst stl rdr tgt           ack rdata          | req addr          en instr          pc_out        flt
    vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,         0, 32'h0,        32'h0,        0)); // reset
    vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,         0, 32'h0,        32'h0,        0));
    vq.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,         0, 32'h0,        32'h0,        0)); // req @0
    vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'h00500093, 0, 32'h0,         1, 32'h00500093, 32'h0,        0)); // deliver
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(1, 1, 0, 32'h0,      0, 32'h0,        0, 32'h0,         0, 32'h00500093, 32'h0,        0)); // stall
    vq.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h4,         0, 32'h00500093, 32'h0,        0)); // release
    vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'h11111111, 0, 32'h4,         1, 32'h11111111, 32'h4,        0));
    vq.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h8,         0, 32'h11111111, 32'h4,        0)); // req @8
    vq.push_back(mk(1, 0, 1, 32'h100,      0, 32'h0,        1, 32'h8,         0, 32'h11111111, 32'h4,        0)); // redirect in WAIT
    vq.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h8,         0, 32'h11111111, 32'h4,        0));
    vq.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h8,         0, 32'h11111111, 32'h4,        0));
    vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'hDEADBEEF, 0, 32'h8,         0, 32'h11111111, 32'h4,        0)); // squashed ack
    vq.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h100,       0, 32'h11111111, 32'h4,        0));
    vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'h22222222, 0, 32'h100,       1, 32'h22222222, 32'h100,      0));
    vq.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h104,       0, 32'h22222222, 32'h100,      0));
    vq.push_back(mk(1, 0, 1, 32'h40,       1, 32'h33333333, 0, 32'h104,       0, 32'h22222222, 32'h100,      0)); // redirect+ack
    vq.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h40,        0, 32'h22222222, 32'h100,      0));
    vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'h44444444, 0, 32'h40,        1, 32'h44444444, 32'h40,       0));
    vq.push_back(mk(1, 1, 1, 32'h200,      0, 32'h0,        0, 32'h40,        0, 32'h44444444, 32'h40,       0)); // redirect+stall
    vq.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h200,       0, 32'h44444444, 32'h40,       0));
    vq.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h200,       0, 32'h44444444, 32'h40,       0)); // stall in WAIT
    vq.push_back(mk(1, 1, 0, 32'h0,        1, 32'h55555555, 0, 32'h200,       1, 32'h55555555, 32'h200,      0));
    vq.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h204,       0, 32'h55555555, 32'h200,      0));
    vq.push_back(mk(1, 0, 1, 32'h102,      0, 32'h0,        1, 32'h204,       0, 32'h55555555, 32'h200,      0)); // misaligned in WAIT
    vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'h66666666, 0, 32'h204,       0, 32'h55555555, 32'h200,      1));
    vq.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h204,       0, 32'h55555555, 32'h200,      1));
    vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,         0, 32'h0,        32'h0,        0)); // reset clears
    vq.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,         0, 32'h0,        32'h0,        0));
    vq.push_back(mk(1, 0, 1, 32'h102,      0, 32'h0,        0, 32'h0,         0, 32'h0,        32'h0,        1)); // misaligned in IDLE
    vq.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,         0, 32'h0,        32'h0,        1));
    vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'h77777777, 0, 32'h0,         0, 32'h0,        32'h0,        1));
    vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,         0, 32'h0,        32'h0,        0));
    vq.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,         0, 32'h0,        32'h0,        0));
    vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,         0, 32'h0,        32'h0,        0)); // reset mid-WAIT
    vq.push_back(mk(1, 1, 0, 32'h0,        1, 32'h88888888, 0, 32'h0,         0, 32'h0,        32'h0,        0)); // late ack ignored
    vq.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,         0, 32'h0,        32'h0,        0));
    vq.push_back(mk(1, 0, 0, 32'h0,        1, 32'h99999999, 0, 32'h0,         1, 32'h99999999, 32'h0,        0));

    foreach (vq[i]) begin
      drive(vq[i].rst_n, vq[i].stall, vq[i].redir, vq[i].tgt, vq[i].ack, vq[i].rdata);
      check($sformatf("v%0d.mem_req", i),   32'(bus.mem_req),   32'(vq[i].e_req));
      check($sformatf("v%0d.mem_addr", i),  bus.mem_addr,       vq[i].e_addr);
      check($sformatf("v%0d.instr_en", i),  32'(bus.instr_en),  32'(vq[i].e_en));
      check($sformatf("v%0d.instr_out", i), bus.instr_out,      vq[i].e_instr);
      check($sformatf("v%0d.pc_out", i),    bus.pc_out,         vq[i].e_pc);
      check($sformatf("v%0d.fault", i),     32'(bus.fault),     32'(vq[i].e_fault));
    end

    // PC wrap: fetch at 32'hFFFF_FFFC, next request goes to 0 with no fault.
    drive(1, 0, 1, 32'hFFFF_FFFC, 0, 32'h0);
    drive(1, 0, 0, 32'h0, 0, 32'h0);
    check("wrap.req",  32'(bus.mem_req), 32'd1);
    check("wrap.addr", bus.mem_addr, 32'hFFFF_FFFC);
    drive(1, 0, 0, 32'h0, 1, 32'hAAAA_5555);
    check("wrap.en",    32'(bus.instr_en), 32'd1);
    check("wrap.pcout", bus.pc_out, 32'hFFFF_FFFC);
    drive(1, 0, 0, 32'h0, 0, 32'h0);
    check("wrap.next_addr", bus.mem_addr, 32'h0);
    check("wrap.fault",     32'(bus.fault), 32'd0);

    // Timeout: the request just issued at 0 is never acknowledged.
    cyc = 0;
    while (bus.mem_req === 1'b1 && cyc < 40) begin
      drive(1, 0, 0, 32'h0, 0, 32'h0);
      cyc++;
      if (cyc == 15) check("tmo.req_at_15", 32'(bus.mem_req), 32'd1);
    end
    check("tmo.wait_cycles", 32'(cyc), 32'd16);
    check("tmo.fault",       32'(bus.fault), 32'd1);
    drive(1, 0, 0, 32'h0, 1, 32'hBBBB_BBBB);
    check("tmo.late_ack_en",  32'(bus.instr_en), 32'd0);
    check("tmo.late_ack_req", 32'(bus.mem_req), 32'd0);
    check("tmo.still_fault",  32'(bus.fault), 32'd1);
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    check("tmo.reset_fault", 32'(bus.fault), 32'd0);
    check("tmo.reset_addr",  bus.mem_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
